// File: rtl/wb_fifo_slave_if.sv
// Wishbone B3 classic bus bundle shared by bridges (master side) and peripherals (slave side).
interface wishbone_b3;
   logic [31:0] adr;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] dat_m2s;
   logic [31:0] dat_s2m;
   logic        ack;
   logic        err;
   logic        rty;
   logic [2:0]  cti;
   logic [1:0]  bte;

   modport master (output adr, cyc, stb, we, sel, dat_m2s, cti, bte,
                   input  dat_s2m, ack, err, rty);
   modport slave  (input  adr, cyc, stb, we, sel, dat_m2s, cti, bte,
                   output dat_s2m, ack, err, rty);
endinterface

// File: rtl/wb_fifo_slave.sv
// Wishbone B3 classic slave: bus-written word FIFO drained by a local FWFT pop port,
// with STATUS/CTRL registers and a threshold level interrupt.
module wb_fifo_slave #(
   parameter int  DEPTH = 16,
   localparam int CW    = $clog2(DEPTH) + 1,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   wishbone_b3.slave   wb,
   input  logic        pop,
   output logic [31:0] dout,
   output logic        empty,
   output logic        irq
);

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] thr;
   logic          irq_en;
   logic          irq_q;
   logic          ack_q;
   logic          err_q;
   logic [31:0]   rdata_q;

   logic          full;
   logic          accept;
   logic          resp_ack;
   logic          resp_err;
   logic          bus_push;
   logic          ctrl_wr;
   logic          flush;
   logic          pop_eff;
   logic [31:0]   rd_val;
   logic [31:0]   status;
   logic [31:0]   ctrl_rd;
   logic          unused_bits;

   assign unused_bits = ^{wb.adr[31:4], wb.adr[1:0], wb.cti, wb.bte};

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign dout    = empty ? 32'd0 : mem[rd_ptr];
   assign irq     = irq_q;
   assign pop_eff = pop & ~empty;

   assign wb.ack     = ack_q;
   assign wb.err     = err_q;
   assign wb.rty     = 1'b0;
   assign wb.dat_s2m = rdata_q;

   // The ack/err cycle itself must not be taken as a new transfer.
   assign accept  = wb.cyc & wb.stb & ~ack_q & ~err_q;
   assign status  = {13'd0, irq_q, full, empty, 16'(count)};
   assign ctrl_rd = {19'd0, 5'(thr), 6'd0, irq_en, 1'b0};
   assign flush   = ctrl_wr & wb.sel[0] & wb.dat_m2s[0];

   always_comb begin
      resp_ack = 1'b0;
      resp_err = 1'b0;
      bus_push = 1'b0;
      ctrl_wr  = 1'b0;
      rd_val   = 32'd0;
      if (accept) begin
         case (wb.adr[3:2])
            2'd0: begin
               if (wb.we) begin
                  // Fullness is judged before any same-cycle local pop.
                  if (wb.sel != 4'hF || full) begin
                     resp_err = 1'b1;
                  end else begin
                     resp_ack = 1'b1;
                     bus_push = 1'b1;
                  end
               end else begin
                  resp_ack = 1'b1;
               end
            end
            2'd1: begin
               if (wb.we) begin
                  resp_err = 1'b1;
               end else begin
                  resp_ack = 1'b1;
                  rd_val   = status;
               end
            end
            2'd2: begin
               resp_ack = 1'b1;
               if (wb.we) ctrl_wr = 1'b1;
               else       rd_val  = ctrl_rd;
            end
            default: resp_err = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
         irq_en  <= 1'b0;
         thr     <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         irq_q   <= 1'b0;
      end else begin
         ack_q <= resp_ack;
         err_q <= resp_err;
         if (accept && (!wb.we || resp_err)) rdata_q <= rd_val;

         if (ctrl_wr) begin
            if (wb.sel[0]) irq_en <= wb.dat_m2s[1];
            if (wb.sel[1]) thr    <= CW'(wb.dat_m2s[12:8]);
         end

         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (bus_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
            case ({bus_push, pop_eff})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end

         irq_q <= irq_en & (count <= thr);
      end
   end

   always_ff @(posedge clk) begin
      if (bus_push) mem[wr_ptr] <= wb.dat_m2s;
   end

endmodule

// File: tb/tb_wb_fifo_slave.sv
// Directed bench for wb_fifo_slave: scoreboard queue of pushed words checked at the pop port.
`timescale 1ns/1ps
module tb_wb_fifo_slave;

   logic        clk;
   logic        rst;
   logic        pop;
   logic [31:0] dout;
   logic        empty;
   logic        irq;

   int n_assert = 0;
   int n_fail   = 0;
   logic [31:0] sb[$];

   wishbone_b3 wb_bus ();

   wb_fifo_slave dut (
      .clk   (clk),
      .rst   (rst),
      .wb    (wb_bus),
      .pop   (pop),
      .dout  (dout),
      .empty (empty),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus(input logic w, input logic [1:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic pop_too,
                      output logic ack_o, output logic err_o, output logic [31:0] rd);
      int n;
      n = 0;
      wb_bus.adr     = {28'd0, a, 2'b00};
      wb_bus.we      = w;
      wb_bus.sel     = s;
      wb_bus.dat_m2s = d;
      wb_bus.cyc     = 1'b1;
      wb_bus.stb     = 1'b1;
      pop            = pop_too;
      @(posedge clk); #1;
      pop = 1'b0;
      while (!(wb_bus.ack || wb_bus.err) && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      ack_o = wb_bus.ack;
      err_o = wb_bus.err;
      rd    = wb_bus.dat_s2m;
      chk("latency", 32'(n), 32'd0);
      wb_bus.cyc = 1'b0;
      wb_bus.stb = 1'b0;
      wb_bus.we  = 1'b0;
      @(posedge clk); #1;
      chk("resp_pulse", {30'd0, wb_bus.ack, wb_bus.err}, 32'd0);
   endtask

   task automatic push_word(input logic [31:0] d, input logic exp_err, input logic pop_too);
      logic a, e;
      logic [31:0] r;
      if (pop_too) begin
         chk("dout_pre_pop", dout, sb[0]);
         void'(sb.pop_front());
      end
      bus(1'b1, 2'd0, 4'hF, d, pop_too, a, e, r);
      if (!exp_err) sb.push_back(d);
      chk("push_resp", {30'd0, a, e}, exp_err ? 32'd1 : 32'd2);
   endtask

   task automatic reg_wr(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d,
                         input logic exp_err, input string tag);
      logic ak, e;
      logic [31:0] r;
      bus(1'b1, a, s, d, 1'b0, ak, e, r);
      chk(tag, {30'd0, ak, e}, exp_err ? 32'd1 : 32'd2);
   endtask

   task automatic reg_rd(input logic [1:0] a, input logic [31:0] exp_val,
                         input logic exp_err, input string tag);
      logic ak, e;
      logic [31:0] r;
      bus(1'b0, a, 4'hF, 32'd0, 1'b0, ak, e, r);
      chk({tag, "_resp"}, {30'd0, ak, e}, exp_err ? 32'd1 : 32'd2);
      chk(tag, r, exp_val);
   endtask

   task automatic pop_one();
      logic [31:0] exp;
      exp = sb.pop_front();
      chk("dout", dout, exp);
      pop = 1'b1;
      @(posedge clk); #1;
      pop = 1'b0;
   endtask

   initial begin
      int acks;
      rst            = 1'b1;
      pop            = 1'b0;
      wb_bus.adr     = 32'd0;
      wb_bus.cyc     = 1'b0;
      wb_bus.stb     = 1'b0;
      wb_bus.we      = 1'b0;
      wb_bus.sel     = 4'h0;
      wb_bus.dat_m2s = 32'd0;
      wb_bus.cti     = 3'd0;
      wb_bus.bte     = 2'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("reset_empty", {31'd0, empty}, 32'd1);
      chk("reset_irq", {31'd0, irq}, 32'd0);
      chk("reset_dout", dout, 32'd0);
      chk("reset_rty", {31'd0, wb_bus.rty}, 32'd0);
      reg_rd(2'd1, 32'h0001_0000, 1'b0, "status_reset");

      push_word(32'hDEAD_BEEF, 1'b0, 1'b0);
      push_word(32'h1234_5678, 1'b0, 1'b0);
      chk("not_empty", {31'd0, empty}, 32'd0);
      pop_one();
      chk("dout_second", dout, 32'h1234_5678);
      reg_rd(2'd1, 32'h0000_0001, 1'b0, "status_cnt1");
      reg_rd(2'd0, 32'd0, 1'b0, "data_read");
      pop_one();

      for (int i = 0; i < 16; i++) push_word($urandom, 1'b0, 1'b0);
      push_word(32'hBAD0_0017, 1'b1, 1'b0);
      reg_rd(2'd1, 32'h0002_0010, 1'b0, "status_full");
      for (int i = 0; i < 16; i++) pop_one();
      for (int i = 0; i < 8; i++) push_word($urandom, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) pop_one();
      chk("empty_after_wrap", {31'd0, empty}, 32'd1);

      for (int i = 0; i < 16; i++) push_word(32'h100 + 32'(i), 1'b0, 1'b0);
      push_word(32'hFFFF_0000, 1'b1, 1'b1);
      reg_rd(2'd1, 32'h0000_000F, 1'b0, "status_full_pop");
      for (int i = 0; i < 10; i++) pop_one();
      push_word(32'h5555_AAAA, 1'b0, 1'b1);
      reg_rd(2'd1, 32'h0000_0005, 1'b0, "status_push_pop");

      reg_wr(2'd2, 4'hF, 32'h0000_0302, 1'b0, "ctrl_wr");
      chk("irq_above_thr", {31'd0, irq}, 32'd0);
      pop_one();
      pop_one();
      chk("irq_not_yet", {31'd0, irq}, 32'd0);
      @(posedge clk); #1;
      chk("irq_at_thr", {31'd0, irq}, 32'd1);
      reg_wr(2'd2, 4'hF, 32'h0000_0303, 1'b0, "ctrl_flush");
      sb.delete();
      chk("flush_empty", {31'd0, empty}, 32'd1);
      reg_rd(2'd1, 32'h0005_0000, 1'b0, "status_flushed");
      chk("irq_after_flush", {31'd0, irq}, 32'd1);
      reg_rd(2'd2, 32'h0000_0302, 1'b0, "ctrl_read");
      reg_wr(2'd2, 4'h1, 32'h0000_1F00, 1'b0, "ctrl_lane0");
      reg_rd(2'd2, 32'h0000_0300, 1'b0, "ctrl_lane_read");
      chk("irq_disabled", {31'd0, irq}, 32'd0);

      push_word(32'hCAFE_0001, 1'b0, 1'b0);
      push_word(32'hCAFE_0002, 1'b0, 1'b0);
      reg_rd(2'd1, 32'h0000_0002, 1'b0, "status_two");
      reg_rd(2'd3, 32'd0, 1'b1, "adr3_read");
      reg_wr(2'd3, 4'hF, 32'h1, 1'b1, "adr3_write");
      reg_wr(2'd1, 4'hF, 32'h0, 1'b1, "status_write");
      reg_wr(2'd0, 4'h3, 32'hBADB_AD00, 1'b1, "data_sel3");
      reg_rd(2'd1, 32'h0000_0002, 1'b0, "status_unchanged");
      pop_one();
      pop_one();
      pop = 1'b1;
      @(posedge clk); #1;
      pop = 1'b0;
      reg_rd(2'd1, 32'h0001_0000, 1'b0, "pop_when_empty");

      acks = 0;
      wb_bus.adr = 32'h4;
      wb_bus.we  = 1'b0;
      wb_bus.sel = 4'hF;
      wb_bus.cyc = 1'b1;
      wb_bus.stb = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (wb_bus.ack) acks++;
      end
      wb_bus.cyc = 1'b0;
      wb_bus.stb = 1'b0;
      @(posedge clk); #1;
      chk("b2b_acks", 32'(acks), 32'd2);

      wb_bus.adr     = 32'h0;
      wb_bus.we      = 1'b1;
      wb_bus.sel     = 4'hF;
      wb_bus.dat_m2s = 32'hA5A5_5A5A;
      wb_bus.cyc     = 1'b1;
      wb_bus.stb     = 1'b1;
      @(posedge clk); #1;
      chk("pre_rst_ack", {31'd0, wb_bus.ack}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_ack", {31'd0, wb_bus.ack}, 32'd0);
      chk("rst_empty", {31'd0, empty}, 32'd1);
      wb_bus.cyc = 1'b0;
      wb_bus.stb = 1'b0;
      wb_bus.we  = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      reg_rd(2'd1, 32'h0001_0000, 1'b0, "status_after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_fifo_slave.md
Name: wb_fifo_slave

Overview:
Wishbone B3 classic slave peripheral. The bus master writes 32-bit words into a DEPTH-entry FIFO. Local logic drains the FIFO through a first-word-fall-through pop port. The block also exposes status and control registers and a level interrupt. It is the responder end of the same wishbone_b3 interface that our bridges drive as master, and it runs entirely in the local clock domain.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 2.
CW, $clog2(DEPTH)+1, count width (derived; do not override).

Ports:
clk  input  1  block clock; all state on posedge clk.
rst  input  1  asynchronous, active-high reset.
wb  wishbone_b3.slave  -  bus port; uses adr[3:2], cyc, stb, we, sel, dat_m2s; drives dat_s2m, ack, err, rty; cti and bte are ignored.
pop  input  1  local consumer removes head word this cycle.
dout  output  32  head word; valid while empty=0.
empty  output  1  FIFO holds no words.
irq  output  1  level interrupt.

Behaviour:
- Reset (async): FIFO empty, count=0, pointers=0, ack=0, err=0, dat_s2m=0, irq_en=0, threshold=0. Outputs: empty=1, irq=0, dout=0. rty is tied to 0 at all times.
- Transfer accept: a transfer is accepted on a posedge where cyc&stb&!ack&!err.
  - Exactly one of ack or err is asserted on the next cycle, for exactly one cycle. Latency is 1 cycle.
  - If stb is still high in the ack/err cycle, it is not a new transfer.
  - If stb is still high on the following cycle, that is a new transfer.
  - Back-to-back throughput is one transfer per 2 cycles.
- Register map (adr[3:2]):
  - 0 DATA: write pushes dat_m2s on the accept edge. Read returns 0 with ack.
  - 1 STATUS (RO): [CW-1:0]=count, [16]=empty, [17]=full, [18]=irq. Write gets err.
  - 2 CTRL (RW):
    - [0] flush: write 1 empties the FIFO; the bit is self-clearing and reads 0.
    - [1] irq_en.
    - [12:8] threshold, zero-extended/truncated to CW.
  - 3: any access gets err.
- Error rules:
  - DATA write with sel!=4'hF gets err and no push.
  - DATA write while full gets err and no push; count is unchanged.
  - CTRL write honours sel byte lanes (lane 0 holds bits 7:0, lane 1 holds bits 15:8).
- Read data: dat_s2m is registered on the accept edge and held until the next read accept. It is 0 on err.
- FIFO:
  - First-word-fall-through: dout=mem[rd_ptr].
  - pop while empty is ignored.
  - Pointers wrap modulo DEPTH. full = (count==DEPTH).
  - Push and pop in the same cycle: count unchanged, both pointers advance. This is allowed when full, but a bus push into a full FIFO still gets err, because full is judged before the pop.
- Flush: takes priority over a same-cycle push or pop. Pointers and count go to 0 and empty=1 on the next cycle.
- irq: registered, irq = irq_en & (count <= threshold). It updates the cycle after count or CTRL changes.
- cyc dropped mid-transfer: an ack/err already scheduled is still issued; the master ignores it. No state is rolled back.
- Reset mid-transfer: the ack/err is lost and the FIFO contents are discarded.

Test Plan:
- Reset, then read STATUS -> ack after 1 cycle; dat_s2m=0x0001_0000; empty=1; irq=0.
- Write DATA 0xDEADBEEF, 0x12345678 (sel=F) -> two acks; empty=0; dout=0xDEADBEEF. Pop 1 cycle -> dout=0x12345678, STATUS count=1.
- Write 17 words with no pops -> first 16 ack. The 17th gets err; STATUS=0x0002_0010. Pop all 16 -> words appear in order; wrap-around verified by pushing 8 more and checking order.
- When full, bus write and pop in the same cycle -> err, count=15. Separately, with count=5, push and pop together -> count stays 5.
- Write CTRL 0x0000_0302 (irq_en=1, threshold=3) with count=5 -> irq=0. Pop twice -> irq=1 one cycle after count reaches 3. Write CTRL bit0=1 -> count=0, irq stays 1, CTRL reads 0x0000_0302.
- Access adr[3:2]=3, STATUS write, and DATA write with sel=4'h3 -> err for one cycle each, no ack, state unchanged. Assert rst mid-transfer -> ack=0 immediately, empty=1.
